// File: rtl/fetch_issue_if.sv
// Instruction-fetch bus between the fetch stage and instruction memory,
// plus the issue-side response qualifiers that travel with the returned data.
interface fetch_issue_if #(
    parameter int ADDRESS_BITS = 32
) ();
    logic                    i_mem_read;
    logic [ADDRESS_BITS-1:0] i_mem_read_address;
    logic                    i_mem_ready;
    logic                    issue_valid;
    logic [ADDRESS_BITS-1:0] issue_PC;
    logic                    squash;
    logic                    scan_active;

    modport master (
        output i_mem_read,
        output i_mem_read_address,
        output issue_valid,
        output issue_PC,
        output squash,
        output scan_active,
        input  i_mem_ready
    );

    modport slave (
        input  i_mem_read,
        input  i_mem_read_address,
        input  issue_valid,
        input  issue_PC,
        input  squash,
        input  scan_active,
        output i_mem_ready
    );
endinterface

// File: rtl/fetch_issue.sv
// Fetch request launcher: holds one request on the bus until accepted, tracks
// wrong-path requests across redirects and qualifies the response one cycle later.
module fetch_issue #(
    parameter int                      ADDRESS_BITS    = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC        = '0,
    parameter int                      SCAN_CYCLES_MIN = 0,
    parameter int                      SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [ADDRESS_BITS-1:0] redirect_target,
    input  logic                    scan,
    fetch_issue_if.master           bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REQ_KILL
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] pc_q, pc_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [ADDRESS_BITS-1:0] issue_pc_q, issue_pc_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_squash_q, resp_squash_d;
    logic [31:0]             cycle_q, cycle_d;
    logic                    window_q, window_d;

    logic                    accept;
    logic [ADDRESS_BITS-1:0] target;
    logic [ADDRESS_BITS-1:0] next_pc;

    assign accept = (state_q != IDLE) && bus.i_mem_ready;
    assign target = redirect_target & ~ADDRESS_BITS'(3);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        issue_pc_d    = issue_pc_q;
        resp_valid_d  = accept;
        resp_squash_d = resp_squash_q;
        next_pc       = pc_q;

        if (accept) begin
            issue_pc_d    = addr_q;
            resp_squash_d = redirect || (state_q == REQ_KILL);
        end

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = target;
                end else if (!stall) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (accept) begin
                    next_pc = redirect ? target : addr_q + ADDRESS_BITS'(4);
                    pc_d    = next_pc;
                    state_d = stall ? IDLE : REQ;
                    if (!stall) begin
                        addr_d = next_pc;
                    end
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = REQ_KILL;
                end
            end
            REQ_KILL: begin
                // A fresh redirect replaces the target latched on entry.
                next_pc = redirect ? target : pc_q;
                pc_d    = next_pc;
                if (accept) begin
                    state_d = stall ? IDLE : REQ;
                    if (!stall) begin
                        addr_d = next_pc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The scan window only gates a debug qualifier; it never touches fetch state.
    always_comb begin
        cycle_d  = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
        window_d = window_q;
        if (cycle_d == 32'(SCAN_CYCLES_MIN)) begin
            window_d = 1'b1;
        end else if (cycle_q == 32'(SCAN_CYCLES_MAX)) begin
            window_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            issue_pc_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_squash_q <= 1'b0;
            cycle_q       <= '0;
            window_q      <= (SCAN_CYCLES_MIN == 0);
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            issue_pc_q    <= issue_pc_d;
            resp_valid_q  <= resp_valid_d;
            resp_squash_q <= resp_squash_d;
            cycle_q       <= cycle_d;
            window_q      <= window_d;
        end
    end

    assign bus.i_mem_read         = (state_q != IDLE);
    assign bus.i_mem_read_address = addr_q;
    assign bus.issue_valid        = resp_valid_q && !resp_squash_q;
    assign bus.squash             = resp_valid_q && resp_squash_q;
    assign bus.issue_PC           = issue_pc_q;
    assign bus.scan_active        = scan && window_q;

endmodule
